// File: rtl/cam_pattern_gen_if.sv
// Emulated OV7670 camera output bus: pixel clock, frame/line syncs and pixel byte.
// The pattern generator drives the master side; a capture block samples the slave side.
interface cam_pattern_gen_if;
  logic       CAM_PCLK;
  logic       CAM_VSYNC;
  logic       CAM_HREF;
  logic [7:0] CAM_px_data;

  modport master (output CAM_PCLK, output CAM_VSYNC, output CAM_HREF, output CAM_px_data);
  modport slave  (input  CAM_PCLK, input  CAM_VSYNC, input  CAM_HREF, input  CAM_px_data);
endinterface

// File: rtl/cam_pattern_gen.sv
// Camera emulator: test-pattern frames in OV7670 timing with a divided pixel clock.
// Outputs change one clk after the PCLK falling-edge tick; free-running, no backpressure.
module cam_pattern_gen #(
  parameter int H_ACTIVE_PX  = 160,
  parameter int V_ACTIVE     = 120,
  parameter int H_BLANK      = 4,
  parameter int V_BLANK      = 4,
  parameter int VSYNC_LINES  = 2,
  parameter int BYTES_PER_PX = 2,
  parameter int PCLK_DIV     = 4,
  parameter int BAR_W        = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [15:0]       solid_color,
  cam_pattern_gen_if.master cam,
  output logic              frame_done,
  output logic [15:0]       frame_cnt
);

  localparam int LINE_BYTES = H_ACTIVE_PX * BYTES_PER_PX;
  localparam int COLS       = LINE_BYTES + H_BLANK;
  localparam int ROWS       = V_BLANK + V_ACTIVE;
  localparam int CW         = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW         = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW         = $clog2(PCLK_DIV);

  localparam logic [CW-1:0] COL_MAX  = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(ROWS - 1);
  localparam logic [DW-1:0] DIV_MAX  = DW'(PCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(PCLK_DIV / 2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_n;
  logic [DW-1:0] div_cnt, div_n;
  logic          tick;
  logic [CW-1:0] col, col_n;
  logic [RW-1:0] row, row_n;
  logic [1:0]    mode_r, mode_u;
  logic [15:0]   color_r, color_u;
  logic          start, last;
  logic [15:0]   xv, yv;
  logic          bsel;
  logic [15:0]   bar_c, c;
  logic [7:0]    byte_n;
  logic          vsync_n, href_n;

  assign tick  = (div_cnt == DIV_MAX);
  assign div_n = tick ? '0 : div_cnt + DW'(1);

  // Raster position after the coming tick; a frame boundary restarts or parks at 0,0.
  always_comb begin
    state_n = state;
    row_n   = row;
    col_n   = col;
    start   = 1'b0;
    last    = (state == RUN) && (row == ROW_MAX) && (col == COL_MAX);
    if (state == IDLE || last) begin
      row_n = '0;
      col_n = '0;
      if (enable) begin
        start   = 1'b1;
        state_n = RUN;
      end else begin
        state_n = IDLE;
      end
    end else if (col == COL_MAX) begin
      col_n = '0;
      row_n = row + RW'(1);
    end else begin
      col_n = col + CW'(1);
    end
  end

  // Pattern selection uses the freshly captured settings on the frame's first tick.
  always_comb begin
    mode_u  = start ? mode : mode_r;
    color_u = start ? solid_color : color_r;
    xv      = 16'((BYTES_PER_PX == 2) ? (col_n >> 1) : col_n);
    bsel    = (BYTES_PER_PX == 2) ? col_n[0] : 1'b0;
    yv      = 16'(row_n) - 16'(V_BLANK);

    case (3'(xv / 16'(BAR_W)))
      3'd0:    bar_c = 16'hFFFF;
      3'd1:    bar_c = 16'hFFE0;
      3'd2:    bar_c = 16'h07FF;
      3'd3:    bar_c = 16'h07E0;
      3'd4:    bar_c = 16'hF81F;
      3'd5:    bar_c = 16'hF800;
      3'd6:    bar_c = 16'h001F;
      default: bar_c = 16'h0000;
    endcase

    case (mode_u)
      2'd0:    c = bar_c;
      2'd1:    c = color_u;
      2'd2:    c = {xv[4:0], xv[5:0], xv[4:0]};
      default: c = (|((xv ^ yv) & 16'h0008)) ? ~color_u : color_u;
    endcase

    vsync_n = int'(row_n) < VSYNC_LINES;
    href_n  = (int'(row_n) >= V_BLANK) && (int'(col_n) < LINE_BYTES);

    if (!href_n)
      byte_n = 8'h00;
    else if (BYTES_PER_PX == 2)
      byte_n = bsel ? c[7:0] : c[15:8];
    else
      byte_n = {c[15:13], c[10:8], c[4:3]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      div_cnt         <= '0;
      row             <= '0;
      col             <= '0;
      mode_r          <= '0;
      color_r         <= '0;
      frame_done      <= 1'b0;
      frame_cnt       <= '0;
      cam.CAM_PCLK    <= 1'b0;
      cam.CAM_VSYNC   <= 1'b0;
      cam.CAM_HREF    <= 1'b0;
      cam.CAM_px_data <= '0;
    end else begin
      div_cnt      <= div_n;
      cam.CAM_PCLK <= (div_n >= DIV_HALF);
      frame_done   <= 1'b0;
      if (tick) begin
        state <= state_n;
        row   <= row_n;
        col   <= col_n;
        if (start) begin
          mode_r  <= mode;
          color_r <= solid_color;
        end
        if (last) begin
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 16'd1;
        end
        if (state_n == RUN) begin
          cam.CAM_VSYNC   <= vsync_n;
          cam.CAM_HREF    <= href_n;
          cam.CAM_px_data <= byte_n;
        end else begin
          cam.CAM_VSYNC   <= 1'b0;
          cam.CAM_HREF    <= 1'b0;
          cam.CAM_px_data <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_pattern_gen.sv
// Two emulator instances (RGB565 and RGB332 geometries) checked every clk against a
// frame-position reference model, plus directed line, sync and reset checks.
module tb_cam_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  mode;
  logic [15:0] solid_color;
  logic        fd0, fd1;
  logic [15:0] fc0, fc1;

  cam_pattern_gen_if cam0 ();
  cam_pattern_gen_if cam1 ();

  cam_pattern_gen #(.H_ACTIVE_PX(40), .V_ACTIVE(12), .H_BLANK(3), .V_BLANK(3), .VSYNC_LINES(2),
                    .BYTES_PER_PX(2), .PCLK_DIV(4), .BAR_W(3)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .solid_color(solid_color),
    .cam(cam0), .frame_done(fd0), .frame_cnt(fc0));

  cam_pattern_gen #(.H_ACTIVE_PX(12), .V_ACTIVE(10), .H_BLANK(2), .V_BLANK(2), .VSYNC_LINES(1),
                    .BYTES_PER_PX(1), .PCLK_DIV(2), .BAR_W(2)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .solid_color(solid_color),
    .cam(cam1), .frame_done(fd1), .frame_cnt(fc1));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int p_h   [2] = '{40, 12};
  int p_hb  [2] = '{3, 2};
  int p_vb  [2] = '{3, 2};
  int p_va  [2] = '{12, 10};
  int p_vs  [2] = '{2, 1};
  int p_bpp [2] = '{2, 1};
  int p_div [2] = '{4, 2};
  int p_bw  [2] = '{3, 2};
  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  // Packed view: {pclk, vsync, href, data[7:0], frame_done, frame_cnt[15:0]}.
  logic [27:0] obs [2];
  assign obs[0] = {cam0.CAM_PCLK, cam0.CAM_VSYNC, cam0.CAM_HREF, cam0.CAM_px_data, fd0, fc0};
  assign obs[1] = {cam1.CAM_PCLK, cam1.CAM_VSYNC, cam1.CAM_HREF, cam1.CAM_px_data, fd1, fc1};

  function automatic logic [7:0] exp_byte(input int i, input int row, input int col,
                                           input logic [1:0] md, input logic [15:0] sc);
    int x, y, b;
    logic [15:0] xv, yv, c;
    if (row < p_vb[i] || col >= p_h[i] * p_bpp[i]) return 8'h00;
    x  = col / p_bpp[i];
    b  = col % p_bpp[i];
    y  = row - p_vb[i];
    xv = 16'(x);
    yv = 16'(y);
    case (md)
      2'd0:    c = bars[(x / p_bw[i]) % 8];
      2'd1:    c = sc;
      2'd2:    c = {xv[4:0], xv[5:0], xv[4:0]};
      default: c = (xv[3] ^ yv[3]) ? ~sc : sc;
    endcase
    if (p_bpp[i] == 2) return (b == 0) ? c[15:8] : c[7:0];
    return {c[15:13], c[10:8], c[4:3]};
  endfunction

  logic        rst_s = 1'b0;
  logic        en_s = 1'b0;
  logic [1:0]  mode_s = '0;
  logic [15:0] col_s = '0;
  always @(posedge clk) begin
    rst_s  = rst;
    en_s   = enable;
    mode_s = mode;
    col_s  = solid_color;
  end

  int          m_div [2] = '{0, 0};
  int          m_p   [2] = '{0, 0};
  bit          m_run [2] = '{0, 0};
  bit          m_done[2] = '{0, 0};
  logic [1:0]  m_mode[2] = '{2'd0, 2'd0};
  logic [15:0] m_col [2] = '{16'd0, 16'd0};
  logic [15:0] m_cnt [2] = '{16'd0, 16'd0};

  // Reference: every PCLK_DIV clks the frame position advances by one byte period.
  always @(negedge clk) begin
    int cols, frame, row, col;
    logic [27:0] e;
    for (int i = 0; i < 2; i++) begin
      cols  = p_h[i] * p_bpp[i] + p_hb[i];
      frame = cols * (p_vb[i] + p_va[i]);
      if (!rst || rst_s !== 1'b1) begin
        m_div[i] = 0; m_p[i] = 0; m_run[i] = 0; m_done[i] = 0; m_cnt[i] = 0;
      end else begin
        m_done[i] = 0;
        m_div[i]  = (m_div[i] + 1) % p_div[i];
        if (m_div[i] == 0) begin
          if (!m_run[i] || m_p[i] == frame - 1) begin
            if (m_run[i]) begin
              m_done[i] = 1;
              m_cnt[i]  = m_cnt[i] + 16'd1;
            end
            m_p[i]   = 0;
            m_run[i] = en_s;
            if (en_s) begin
              m_mode[i] = mode_s;
              m_col[i]  = col_s;
            end
          end else begin
            m_p[i]++;
          end
        end
      end
      row   = m_p[i] / cols;
      col   = m_p[i] % cols;
      e     = '0;
      e[27] = (m_div[i] >= p_div[i] / 2);
      if (m_run[i]) begin
        e[26]    = (row < p_vs[i]);
        e[25]    = (row >= p_vb[i]) && (col < p_h[i] * p_bpp[i]);
        e[24:17] = exp_byte(i, row, col, m_mode[i], m_col[i]);
      end
      e[16]   = m_done[i];
      e[15:0] = m_cnt[i];
      chk($sformatf("dut%0d cycle p=%0d", i, m_p[i]), {4'd0, obs[i]}, {4'd0, e});
    end
  end

  // Line statistics sampled on PCLK rising edges.
  logic       pclk_q [2] = '{1'b0, 1'b0};
  logic       href_q [2] = '{1'b0, 1'b0};
  int         lines  [2] = '{0, 0};
  int         vs_cnt [2] = '{0, 0};
  int         pr_cnt [2] = '{0, 0};
  int         cur_len[2] = '{0, 0};
  int         last_len[2] = '{0, 0};
  logic [7:0] lbuf0 [80];
  logic [7:0] lbuf1 [12];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        cur_len[i] = 0;
      end else begin
        if (!obs[i][25] && href_q[i]) begin
          lines[i]++;
          last_len[i] = cur_len[i];
          cur_len[i]  = 0;
        end
        if (obs[i][27] && !pclk_q[i]) begin
          pr_cnt[i]++;
          if (obs[i][26]) vs_cnt[i]++;
          if (obs[i][25]) begin
            if (i == 0 && cur_len[i] < 80) lbuf0[cur_len[i]] = obs[i][24:17];
            if (i == 1 && cur_len[i] < 12) lbuf1[cur_len[i]] = obs[i][24:17];
            cur_len[i]++;
          end
        end
      end
      pclk_q[i] = obs[i][27];
      href_q[i] = obs[i][25];
    end
  end

  task automatic wait_done0(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fd0 !== 1'b1 && n < budget);
    chk("frame_done seen", {31'd0, fd0}, 32'd1);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int l_snap, v_snap, p_snap;

  initial begin
    rst = 1'b0; enable = 1'b0; mode = 2'd0; solid_color = 16'h0000;
    step(3);
    chk("reset outs dut0", {4'd0, obs[0]}, 32'd0);
    chk("reset outs dut1", {4'd0, obs[1]}, 32'd0);
    rst = 1'b1;
    step(2);

    // Bars frame; settings changed mid-frame must not show until the next frame.
    enable = 1'b1; mode = 2'd0; solid_color = 16'($urandom);
    l_snap = lines[0]; v_snap = vs_cnt[0];
    step(2600);
    mode = 2'd1; solid_color = 16'hF800;
    wait_done0(6000);
    chk("frame_cnt after 1", {16'd0, fc0}, 32'd1);
    chk("href pulses", lines[0] - l_snap, 32'd12);
    chk("vsync pclk periods", vs_cnt[0] - v_snap, 32'd166);
    chk("line bytes dut0", last_len[0], 32'd80);
    chk("bar px0", {16'd0, lbuf0[0], lbuf0[1]}, 32'hFFFF);
    chk("bar px3", {16'd0, lbuf0[6], lbuf0[7]}, 32'hFFE0);
    chk("bar px18", {16'd0, lbuf0[36], lbuf0[37]}, 32'h001F);
    chk("bar px21", {16'd0, lbuf0[42], lbuf0[43]}, 32'h0000);
    chk("bar px24 wrap", {16'd0, lbuf0[48], lbuf0[49]}, 32'hFFFF);
    chk("line bytes dut1", last_len[1], 32'd12);
    for (int k = 0; k < 12; k++) chk($sformatf("rgb332 solid b%0d", k), {24'd0, lbuf1[k]}, 32'hE0);

    // Drop enable mid-frame: frame completes, then syncs idle while PCLK runs.
    step(2500);
    mode = 2'd3; solid_color = 16'h001F;
    enable = 1'b0;
    wait_done0(6000);
    chk("frame_cnt after 2", {16'd0, fc0}, 32'd2);
    p_snap = pr_cnt[0];
    step(20);
    chk("idle syncs/data", {22'd0, obs[0][26:17]}, 32'd0);
    chk("pclk runs in idle", {31'd0, (pr_cnt[0] - p_snap) >= 4}, 32'd1);
    enable = 1'b1;

    for (int it = 0; it < 4; it++) begin
      step($urandom_range(300, 2500));
      mode = 2'($urandom);
      solid_color = 16'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        enable = 1'b0;
        wait_done0(6000);
        step($urandom_range(5, 40));
        enable = 1'b1;
      end
    end

    // Asynchronous reset mid-frame, then a clean frame from row 0.
    step(2500);
    rst = 1'b0;
    #1;
    chk("async reset dut0", {4'd0, obs[0]}, 32'd0);
    chk("async reset dut1", {4'd0, obs[1]}, 32'd0);
    step(3);
    rst = 1'b1;
    wait_done0(6000);
    chk("frame_cnt after reset", {16'd0, fc0}, 32'd1);
    step(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
